// File: rtl/defs.sv
// Shared stream and word constants for the operand feed and the result drain.
//   C_WIDTH          : bits per operand word
//   C_WORDS_PER_BEAT : operand words carried by one stream beat
//   C_STREAM_WIDTH   : stream bus width (word j at bits [C_WIDTH*(j+1)-1 : C_WIDTH*j])
package defs;

  localparam int C_WIDTH          = 16;
  localparam int C_WORDS_PER_BEAT = 2;
  localparam int C_STREAM_WIDTH   = C_WIDTH * C_WORDS_PER_BEAT;

endpackage : defs

// File: rtl/feed_skew_line.sv
// skew_line: fixed-depth delay line carrying a data word and its valid bit.
// Data is forced to zero wherever valid is low, so the array edge only ever
// sees zeros on idle lanes. DEPTH = 0 degenerates to a pure wire.
//
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-low reset, clears every stage
//   data_in   : word entering the line
//   valid_in  : qualifies data_in
//   data_out  : word leaving the line after DEPTH cycles (0 when invalid)
//   valid_out : valid leaving the line after DEPTH cycles
module skew_line #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out
);

  if (DEPTH == 0) begin : g_wire

    assign data_out  = valid_in ? data_in : '0;
    assign valid_out = valid_in;

  end else begin : g_regs

    logic [WIDTH-1:0] data_q  [DEPTH];
    logic             valid_q [DEPTH];

    // NOTE: every stage is reset, not only the valid bits: a reset taken
    // mid-skew must leave zeros on the data path immediately, and the stages
    // are few enough that clearing them all costs nothing worth saving.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int i = 0; i < DEPTH; i++) begin
          data_q[i]  <= '0;
          valid_q[i] <= 1'b0;
        end
      end else begin
        // Masking at entry keeps every downstream stage zero when invalid.
        data_q[0]  <= valid_in ? data_in : '0;
        valid_q[0] <= valid_in;
        for (int i = 1; i < DEPTH; i++) begin
          data_q[i]  <= data_q[i-1];
          valid_q[i] <= valid_q[i-1];
        end
      end
    end

    assign data_out  = data_q[DEPTH-1];
    assign valid_out = valid_q[DEPTH-1];

  end

endmodule : skew_line

// File: rtl/feed.sv
// feed: unpacks the packed operand stream into N-word rows and issues them to
// the systolic array edge at most once every II cycles, as a skewed wavefront
// (lane k trails lane 0 by k cycles). One row-hold register decouples stream
// arrival from issue pacing; ready_in back-pressures the source.
//
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-low reset
//   data_in   : stream beat, C_WORDS_PER_BEAT words of C_WIDTH bits
//   valid_in  : beat valid
//   ready_in  : feed accepts a beat this cycle (depends on state only)
//   data_out  : per-lane skewed words, zero when the lane is invalid
//   valid_out : per-lane valid
module feed
  import defs::*;
#(
  parameter int N  = 2,
  parameter int II = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [C_STREAM_WIDTH-1:0] data_in,
  input  logic                      valid_in,
  output logic                      ready_in,
  output logic [C_WIDTH-1:0]        data_out  [N],
  output logic                      valid_out [N]
);

  localparam int W  = C_WORDS_PER_BEAT;
  localparam int P  = N / W;                       // beats per row
  localparam int BW = (P > 1) ? $clog2(P) : 1;
  localparam int IW = (II > 1) ? $clog2(II) : 1;

  if ((N % W) != 0 || N < W) begin : g_bad_n
    $error("feed: N must be a non-zero multiple of C_WORDS_PER_BEAT");
  end
  if (II < 1) begin : g_bad_ii
    $error("feed: II must be at least 1");
  end

  logic [C_WIDTH-1:0] asm_q    [N];   // row under assembly
  logic [C_WIDTH-1:0] hold_q   [N];   // completed row waiting for issue
  logic [C_WIDTH-1:0] next_row [N];   // row as it lands in hold_q
  logic [BW-1:0]      bcnt_q;
  logic               hold_full_q;
  logic [IW-1:0]      ii_cnt_q;

  logic accept;
  logic last_beat;
  logic row_done;
  logic issue;

  assign last_beat = (bcnt_q == BW'(P - 1));
  assign issue     = hold_full_q && (ii_cnt_q == '0);
  // Only a full hold register with the final beat pending and no issue this
  // cycle can block the source; valid_in never feeds back into ready_in.
  assign ready_in  = !(last_beat && hold_full_q && !issue);
  assign accept    = valid_in && ready_in;
  assign row_done  = accept && last_beat;

  // Word i belongs to beat i/W; the last beat's words go straight from the
  // bus into the hold register without passing through the assembly row.
  for (genvar i = 0; i < N; i++) begin : g_row
    if (i / W == P - 1) begin : g_from_bus
      assign next_row[i] = data_in[(i % W)*C_WIDTH +: C_WIDTH];
    end else begin : g_from_asm
      assign next_row[i] = asm_q[i];
    end

    // Pure data storage: bcnt and hold_full decide when it is meaningful,
    // so a reset that discards a partial row needs no clear here.
    always_ff @(posedge clk) begin
      if (accept && bcnt_q == BW'(i / W)) begin
        asm_q[i] <= data_in[(i % W)*C_WIDTH +: C_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (row_done) begin
      hold_q <= next_row;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcnt_q      <= '0;
      hold_full_q <= 1'b0;
      ii_cnt_q    <= '0;
    end else begin
      if (accept) begin
        bcnt_q <= last_beat ? '0 : bcnt_q + 1'b1;
      end

      // A row completing on the issue edge refills the hold register.
      if (row_done) begin
        hold_full_q <= 1'b1;
      end else if (issue) begin
        hold_full_q <= 1'b0;
      end

      // Pacer: load II-1 on issue, count down and park at zero.
      if (issue) begin
        ii_cnt_q <= IW'(II - 1);
      end else if (ii_cnt_q != '0) begin
        ii_cnt_q <= ii_cnt_q - 1'b1;
      end
    end
  end

  // Lane k sees the issued word after k+1 cycles: one cycle of issue
  // registration plus k cycles of diagonal skew.
  for (genvar k = 0; k < N; k++) begin : g_lane
    skew_line #(
      .WIDTH (C_WIDTH),
      .DEPTH (k + 1)
    ) u_skew (
      .clk       (clk),
      .rst       (rst),
      .data_in   (hold_q[k]),
      .valid_in  (issue),
      .data_out  (data_out[k]),
      .valid_out (valid_out[k])
    );
  end

endmodule : feed

// File: tb/tb_feed.sv
// Self-checking bench for feed. Two instances share clock and reset:
// cfg[0] uses II=2, cfg[1] uses II=5; both have N=4 (two beats per row).
// Inputs change 2 time units after a rising edge; outputs are sampled on the
// falling edge. Each instance has a row/queue-level reference model compared
// against ready_in, valid_out and data_out every cycle.
module tb_feed;
  import defs::*;

  localparam int N  = 4;
  localparam int WB = C_WORDS_PER_BEAT;
  localparam int P  = N / WB;
  localparam int CW = C_WIDTH;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0][C_STREAM_WIDTH-1:0] din = '0;
  logic [1:0]                     vin = '0;
  logic [1:0]                     rdy;
  logic [1:0][N-1:0][CW-1:0]      dout_p;
  logic [1:0][N-1:0]              vout_p;

  int tests_run    = 0;
  int tests_failed = 0;
  int gcyc         = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    gcyc++;
  end

  for (genvar g = 0; g < 2; g++) begin : cfg
    localparam int GII = (g == 0) ? 2 : 5;

    logic [CW-1:0] dout [N];
    logic          vout [N];

    feed #(.N(N), .II(GII)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .data_in   (din[g]),
      .valid_in  (vin[g]),
      .ready_in  (rdy[g]),
      .data_out  (dout),
      .valid_out (vout)
    );

    for (genvar k = 0; k < N; k++) begin : g_tap
      assign dout_p[g][k] = dout[k];
      assign vout_p[g][k] = vout[k];
    end

    // Reference model: words collected into a row, one waiting row, the
    // earliest cycle an issue may happen, and a schedule of expected lane
    // outputs indexed by absolute cycle.
    int            asm_cnt;
    logic [CW-1:0] asm_w  [N];
    logic          hold;
    logic [CW-1:0] hold_w [N];
    int            mcyc;
    int            next_ok;
    logic          ev [N][64];
    logic [CW-1:0] ed [N][64];
    logic          m_iss;
    logic          m_rdy;
    logic          exp_v;
    logic [CW-1:0] exp_d;

    initial forever begin
      @(negedge clk);
      if (!rst) begin
        asm_cnt = 0;
        hold    = 1'b0;
        mcyc    = 0;
        next_ok = 0;
        for (int k = 0; k < N; k++)
          for (int s = 0; s < 64; s++) ev[k][s] = 1'b0;
      end

      m_iss = hold && (mcyc >= next_ok);
      m_rdy = !((asm_cnt == P - 1) && hold && !m_iss);
      check($sformatf("u%0d ready_in", g), rdy[g], m_rdy);
      for (int k = 0; k < N; k++) begin
        exp_v = ev[k][mcyc % 64];
        exp_d = exp_v ? ed[k][mcyc % 64] : '0;
        check($sformatf("u%0d valid_out[%0d]", g, k), vout_p[g][k], exp_v);
        check($sformatf("u%0d data_out[%0d]", g, k), dout_p[g][k], exp_d);
        ev[k][mcyc % 64] = 1'b0;
      end

      if (rst) begin
        if (m_iss) begin
          for (int k = 0; k < N; k++) begin
            ev[k][(mcyc + 1 + k) % 64] = 1'b1;
            ed[k][(mcyc + 1 + k) % 64] = hold_w[k];
          end
          next_ok = mcyc + GII;
          hold    = 1'b0;
        end
        if (vin[g] && m_rdy) begin
          for (int j = 0; j < WB; j++) asm_w[asm_cnt*WB + j] = din[g][j*CW +: CW];
          asm_cnt++;
          if (asm_cnt == P) begin
            hold    = 1'b1;
            hold_w  = asm_w;
            asm_cnt = 0;
          end
        end
        mcyc++;
      end
    end
  end

  // Output monitor for the scenario-level checks.
  bit            mon_en    = 1'b0;
  int            mon_g     = 0;
  int            ready_low = 0;
  int            pulses [N][$];
  logic [CW-1:0] words  [N][$];

  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      if (!rdy[mon_g]) ready_low++;
      for (int k = 0; k < N; k++) begin
        if (vout_p[mon_g][k]) begin
          pulses[k].push_back(gcyc);
          words[k].push_back(dout_p[mon_g][k]);
        end
      end
    end
  end

  task automatic mon_start(input int g);
    mon_g     = g;
    ready_low = 0;
    for (int k = 0; k < N; k++) begin
      pulses[k].delete();
      words[k].delete();
    end
    mon_en = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Present a beat and hold it until the edge that accepts it.
  task automatic send_beat(input int g, input logic [C_STREAM_WIDTH-1:0] d);
    int n;
    vin[g] = 1'b1;
    din[g] = d;
    n = 0;
    while (!rdy[g] && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check($sformatf("u%0d handshake bound", g), 0, 1);
    tick();
  endtask

  function automatic logic [C_STREAM_WIDTH-1:0] beat_word(input int base, input int r, input int b);
    logic [CW-1:0] w0;
    logic [CW-1:0] w1;
    w0 = CW'(base + 4*r + 2*b);
    w1 = CW'(base + 4*r + 2*b + 1);
    return {w1, w0};
  endfunction

  task automatic stream_rows(input int g, input int base, input int rows, input bit gaps);
    for (int r = 0; r < rows; r++) begin
      for (int b = 0; b < P; b++) begin
        if (gaps) begin
          vin[g] = 1'b0;
          while ($urandom_range(0, 1) == 1) tick();
        end
        send_beat(g, beat_word(base, r, b));
      end
    end
    vin[g] = 1'b0;
  endtask

  // Lane k must show row r's word k, rows in arrival order.
  task automatic check_words(input string name, input int base, input int rows);
    for (int k = 0; k < N; k++) begin
      check($sformatf("%s lane%0d count", name, k), words[k].size(), rows);
      for (int r = 0; r < rows && r < words[k].size(); r++)
        check($sformatf("%s lane%0d row%0d", name, k, r), words[k][r], CW'(base + 4*r + k));
    end
  endtask

  // Called at the start of cycle 2 after beats at edges 1 and 2: lane k
  // must carry word k in cycle 3+k only.
  task automatic check_single_row(input int g, input logic [CW-1:0] w0, input logic [CW-1:0] w1,
                                  input logic [CW-1:0] w2, input logic [CW-1:0] w3);
    logic [CW-1:0] w [N];
    logic          v;
    w = '{w0, w1, w2, w3};
    for (int c = 2; c <= 7; c++) begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        v = (c == 3 + k);
        check($sformatf("row c%0d valid[%0d]", c, k), vout_p[g][k], v);
        check($sformatf("row c%0d data[%0d]", c, k), dout_p[g][k], v ? w[k] : '0);
      end
    end
    tick();
  endtask

  initial begin
    // Reset values.
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("reset ready u%0d", g), rdy[g], 1'b1);
      check($sformatf("reset valid u%0d", g), vout_p[g], '0);
      check($sformatf("reset data u%0d", g), dout_p[g], '0);
    end
    @(posedge clk);
    #2 rst = 1'b1;

    // Single row on II=2.
    send_beat(0, 32'h0002_0001);
    send_beat(0, 32'h0004_0003);
    vin[0] = 1'b0;
    check_single_row(0, 16'h0001, 16'h0002, 16'h0003, 16'h0004);
    repeat (4) tick();

    // Streaming on II=2: 8 beats, ready stays high, rows every 2 cycles.
    mon_start(0);
    stream_rows(0, 16'h0040, 4, 1'b0);
    repeat (10) tick();
    mon_en = 1'b0;
    check("stream ready_low cycles", ready_low, 0);
    for (int k = 0; k < N; k++) begin
      check($sformatf("stream lane%0d pulses", k), pulses[k].size(), 4);
      if (pulses[k].size() > 0 && pulses[0].size() > 0)
        check($sformatf("stream lane%0d skew", k), pulses[k][0] - pulses[0][0], k);
      for (int i = 1; i < pulses[k].size(); i++)
        check($sformatf("stream lane%0d spacing", k), pulses[k][i] - pulses[k][i-1], 2);
    end
    check_words("stream", 16'h0040, 4);

    // Pacing on II=5: issue spacing exactly 5, nothing lost or duplicated.
    mon_start(1);
    stream_rows(1, 16'h0200, 8, 1'b0);
    repeat (20) tick();
    mon_en = 1'b0;
    check("pace stalls seen", ready_low > 0, 1'b1);
    check("pace lane0 pulses", pulses[0].size(), 8);
    for (int i = 1; i < pulses[0].size(); i++)
      check("pace spacing", pulses[0][i] - pulses[0][i-1], 5);
    check_words("pace", 16'h0200, 8);

    // Source gaps on II=2: ~50% valid density over 100 rows.
    mon_start(0);
    stream_rows(0, 16'h1000, 100, 1'b1);
    repeat (10) tick();
    mon_en = 1'b0;
    check_words("gaps", 16'h1000, 100);
    repeat (5) tick();

    // Reset with row 1 mid-skew and one beat of row 2 accepted.
    send_beat(0, 32'h0012_0011);
    send_beat(0, 32'h0014_0013);
    send_beat(0, 32'h0022_0021);
    vin[0] = 1'b0;
    tick();
    check("midskew lane1 valid", vout_p[0][1], 1'b1);
    #1 rst = 1'b0;
    #1;
    check("async reset valid", vout_p[0], '0);
    check("async reset data", dout_p[0], '0);
    check("async reset ready", rdy[0], 1'b1);
    repeat (2) tick();
    rst = 1'b1;
    send_beat(0, 32'h0032_0031);
    send_beat(0, 32'h0034_0033);
    vin[0] = 1'b0;
    check_single_row(0, 16'h0031, 16'h0032, 16'h0033, 16'h0034);
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global time bound reached");
    $fatal(1, "tb_feed time bound");
  end

endmodule : tb_feed

// File: doc/feed.md
# feed

Input-side counterpart of the result drain: accepts the packed operand stream (`C_WORDS_PER_BEAT` words per beat) and unpacks each group of N words into one operand row. It issues rows to the systolic array edge at a fixed initiation interval. Each row is emitted as a skewed wavefront: lane k is delayed k cycles relative to lane 0, matching the array's diagonal timing. A single row-hold buffer decouples stream arrival from issue pacing, and `ready_in` back-pressures the source.

## Interface
- `N`, default 2: lanes per row (array edge width); must be a multiple of `C_WORDS_PER_BEAT`, otherwise elaboration error.
- `II`, default 2: minimum cycles between row issues; must be ≥1.
- P = N/`C_WORDS_PER_BEAT` (derived): beats per row.
- W = `C_WORDS_PER_BEAT` (derived).

Ports (clock and reset first):
- `clk`, in, 1: single clock; all state is on the rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `data_in`, in, `C_STREAM_WIDTH`: stream beat; word j is at bits [`C_WIDTH`*(j+1)-1 : `C_WIDTH`*j].
- `valid_in`, in, 1: beat valid.
- `ready_in`, out, 1: feed can accept a beat this cycle.
- `data_out`, out, `C_WIDTH` × [0:N-1]: skewed lane words.
- `valid_out`, out, 1 × [0:N-1]: per-lane valid.

## Operation
- A beat is accepted when `valid_in` and `ready_in` are both high. Beat index b (0..P-1, counter `bcnt`) writes assembly words b*W+j.
- Row complete: the accepted beat has `bcnt`==P-1. The row then moves to the hold register in the same edge, `hold_full` is set, and `bcnt` wraps to 0.
- `ready_in` = !(`bcnt`==P-1 && `hold_full` && !`issue`). This is combinational from state only; there is no `valid_in`→`ready_in` path.
- `issue` = `hold_full` && `ii_cnt`==0. On issue, `ii_cnt` loads II-1, then decrements each cycle down to 0 and saturates there. `hold_full` clears unless a row completes in the same cycle, in which case it stays set with the new row (simultaneous issue + refill).
- Effective state is (`bcnt`, `hold_full`):
  - EMPTY: `bcnt`=0, `hold_full`=0.
  - FILLING: `bcnt`>0.
  - HELD: `hold_full`=1.
  - STALLED: HELD with `bcnt`=P-1 and no issue possible.
- Skew: an issued row enters per-lane delay lines. Lane k carries word k with a k-cycle extra delay. Each line carries a valid bit.
- When `valid_out[k]` is 0, `data_out[k]` is forced to 0 (zero injection into the array).
- `valid_in` while `ready_in` is low: the beat is not consumed, and the source must hold it stable.
- Reset, including mid-row or mid-skew:
  - `bcnt`, `hold_full`, `ii_cnt` and all skew stages clear.
  - A partial row is discarded.
  - `ready_in` goes high on the first cycle after deassertion.

## Timing
- Reset values: `ready_in`=1; `valid_out[*]`=0; `data_out[*]`=0.
- Latency: last beat of a row accepted at edge t → issue at cycle t (if `ii_cnt`==0) → `valid_out[0]` high in cycle t+1 → `valid_out[k]` high in cycle t+1+k, each for exactly one cycle per row.
- Sustained throughput is one row per max(P, II) cycles. With P ≥ II and an always-valid source, `ready_in` never drops.
- Consecutive issued rows on a lane are separated by exactly the issue spacing; the skew is identical for every row.

## Structure
- Constants `C_WIDTH`, `C_WORDS_PER_BEAT` and `C_STREAM_WIDTH` come from the shared `defs` package. No new package typedefs.
- Sub-module `skew_line #(WIDTH, DEPTH)`:
  - Carries data and valid through DEPTH register stages with async active-low reset.
  - Data is zeroed where valid is 0.
  - DEPTH=0 is a pure wire.
  - One instance per lane, with DEPTH = k+1.
- Top level holds the assembly/hold registers, `bcnt`, the `ii_cnt` pacer and the `ready_in` logic. Expected size is about 200 lines.

## Test plan
Configuration: N=4, W=2 (P=2), `C_WIDTH`=16, II=2.

- **Single row.** Reset, then beats {w1=0x0002,w0=0x0001} and {0x0004,0x0003} at edges 1 and 2.
  - Expect `data_out[0]`=1 in cycle 3, `data_out[1]`=2 in cycle 4, `data_out[2]`=3 in cycle 5, `data_out[3]`=4 in cycle 6, each with its `valid_out` high.
  - All other cycles show 0/invalid.
- **Streaming.** Valid held high, 8 beats.
  - Expect `ready_in` constant 1.
  - Expect four rows issued every 2 cycles, each lane showing 4 pulses spaced by 2.
- **Pacing with II=5.** Continuous stream.
  - Expect the issue spacing to be exactly 5.
  - Expect `ready_in` low in STALLED cycles only.
  - Expect no beat lost or duplicated: output sequence equals the input words in order.
- **Source gaps.** Random `valid_in` with ~50% density over 100 rows.
  - Expect the output word order to match the reference model.
  - Expect `data_out`=0 whenever valid is low.
- **Reset mid-operation.** Assert `rst` low after 1 beat of row 2, while row 1 is mid-skew.
  - Expect all `valid_out` to drop to 0 immediately (async).
  - After release, expect the next 2 beats to form a fresh row 0 with no remnants.
